threshold_pipe: RTL and testbench

THRESHOLD_PIPE -- requirements
Module: threshold_pipe

---
 rtl/threshold_pipe.sv | 209 ++++++++++++++++++++
 tb/tb_threshold_pipe.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/threshold_pipe.sv
// -----------------------------------------------------------------------------
// threshold_pipe
//
// Two-stage pixel pipeline that picks one channel from a packed multi-channel
// pixel and flags it when it lies strictly between a lower and an upper bound.
// Channel select and bounds are written into a shadow set at any time. They
// are copied into the active set on the first pixel of a frame, so a frame
// always sees one consistent configuration.
//
// Optional feature (macro THRESH_COUNT_EN): a per-frame counter of masked
// pixels. It is reported on count_out with a one-cycle count_valid_out pulse
// after the last pixel of the frame leaves the pipeline. Without the macro,
// count_out and count_valid_out are tied to 0.
//
// Ports
//   clk_in          clock, all state on the rising edge
//   rst_n_in        asynchronous active-low reset
//   valid_in        pixel qualifier
//   sof_in/eof_in   first/last pixel of frame (only meaningful with valid_in)
//   ch_in           NUM_CH packed channels, channel k at [k*WIDTH +: WIDTH]
//   sel_in          channel select (captured on cfg_load_in)
//   lower_in        lower bound    (captured on cfg_load_in)
//   upper_in        upper bound    (captured on cfg_load_in)
//   cfg_load_in     strobe writing sel/bounds into the shadow set
//   valid_out       pixel qualifier, 2 cycles after valid_in
//   sof_out         first pixel of frame, aligned with valid_out
//   eof_out         last pixel of frame, aligned with valid_out
//   mask_out        (ch > lower) && (ch < upper), forced 0 when not valid
//   channel_out     selected channel, updated only by valid pixels
//   count_out       masked-pixel count of the last completed frame
//   count_valid_out one-cycle pulse when count_out is refreshed
// -----------------------------------------------------------------------------
module threshold_pipe #(
    parameter int WIDTH  = 4,
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 17
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        valid_in,
    input  logic                        sof_in,
    input  logic                        eof_in,
    input  logic [NUM_CH*WIDTH-1:0]     ch_in,
    input  logic [$clog2(NUM_CH)-1:0]   sel_in,
    input  logic [WIDTH-1:0]            lower_in,
    input  logic [WIDTH-1:0]            upper_in,
    input  logic                        cfg_load_in,
    output logic                        valid_out,
    output logic                        sof_out,
    output logic                        eof_out,
    output logic                        mask_out,
    output logic [WIDTH-1:0]            channel_out,
    output logic [CNT_W-1:0]            count_out,
    output logic                        count_valid_out
);

    localparam int SEL_W = $clog2(NUM_CH);

    // Shadow and active configuration sets
    logic [SEL_W-1:0] sh_sel_reg,   act_sel_reg;
    logic [WIDTH-1:0] sh_lower_reg, act_lower_reg;
    logic [WIDTH-1:0] sh_upper_reg, act_upper_reg;

    logic             frame_start;
    logic [SEL_W-1:0] eff_sel;
    logic [WIDTH-1:0] eff_lower;
    logic [WIDTH-1:0] eff_upper;
    logic [WIDTH-1:0] pick_ch;

    // Stage-1 registers
    logic             s1_valid_reg;
    logic             s1_sof_reg;
    logic             s1_eof_reg;
    logic [WIDTH-1:0] s1_ch_reg;
    logic [WIDTH-1:0] s1_lower_reg;
    logic [WIDTH-1:0] s1_upper_reg;

    assign frame_start = valid_in && sof_in;

    // The sof pixel must already use the configuration being copied into the
    // active set on this edge, so bypass the shadow straight to stage 1.
    assign eff_sel   = frame_start ? sh_sel_reg   : act_sel_reg;
    assign eff_lower = frame_start ? sh_lower_reg : act_lower_reg;
    assign eff_upper = frame_start ? sh_upper_reg : act_upper_reg;

    // Select decode. A select value with no matching channel (possible when
    // NUM_CH is not a power of two) leaves the default of 0.
    always_comb begin
        pick_ch = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (eff_sel == SEL_W'(k)) begin
                pick_ch = ch_in[k*WIDTH +: WIDTH];
            end
        end
    end

    // Configuration registers. When a load coincides with sof, the active set
    // receives the old shadow; the new shadow waits for the next frame.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sh_sel_reg    <= '0;
            sh_lower_reg  <= '0;
            sh_upper_reg  <= '1;
            act_sel_reg   <= '0;
            act_lower_reg <= '0;
            act_upper_reg <= '1;
        end else begin
            if (cfg_load_in) begin
                sh_sel_reg   <= sel_in;
                sh_lower_reg <= lower_in;
                sh_upper_reg <= upper_in;
            end
            if (frame_start) begin
                act_sel_reg   <= sh_sel_reg;
                act_lower_reg <= sh_lower_reg;
                act_upper_reg <= sh_upper_reg;
            end
        end
    end

    // Stage 1: channel select. The bounds travel with the pixel, so a
    // following frame's sof cannot change the compare of a pixel in flight.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_valid_reg <= 1'b0;
            s1_sof_reg   <= 1'b0;
            s1_eof_reg   <= 1'b0;
            s1_ch_reg    <= '0;
            s1_lower_reg <= '0;
            s1_upper_reg <= '0;
        end else begin
            s1_valid_reg <= valid_in;
            s1_sof_reg   <= frame_start;
            s1_eof_reg   <= valid_in && eof_in;
            s1_ch_reg    <= pick_ch;
            s1_lower_reg <= eff_lower;
            s1_upper_reg <= eff_upper;
        end
    end

    // Stage 2: strict window compare; lower >= upper can never pass.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_out   <= 1'b0;
            sof_out     <= 1'b0;
            eof_out     <= 1'b0;
            mask_out    <= 1'b0;
            channel_out <= '0;
        end else begin
            valid_out <= s1_valid_reg;
            sof_out   <= s1_sof_reg;
            eof_out   <= s1_eof_reg;
            mask_out  <= s1_valid_reg && (s1_ch_reg > s1_lower_reg)
                                      && (s1_ch_reg < s1_upper_reg);
            if (s1_valid_reg) begin
                channel_out <= s1_ch_reg;
            end
        end
    end

`ifdef THRESH_COUNT_EN
    logic [CNT_W-1:0] acc_reg;
    logic [CNT_W-1:0] count_reg;
    logic             count_valid_reg;
    logic             framed_reg;      // inside a frame whose sof was seen
    logic [CNT_W-1:0] acc_base;
    logic [CNT_W-1:0] acc_next;

    // sof restarts the count with that pixel included; saturate at all-ones.
    always_comb begin
        acc_base = sof_out ? '0 : acc_reg;
        acc_next = acc_base;
        if (mask_out && (acc_base != '1)) begin
            acc_next = acc_base + CNT_W'(1);
        end
    end

    // Pixels outside a frame opened by sof_out (e.g. the tail of a frame cut
    // by reset) are ignored, so no partial count is ever reported.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            acc_reg         <= '0;
            count_reg       <= '0;
            count_valid_reg <= 1'b0;
            framed_reg      <= 1'b0;
        end else begin
            count_valid_reg <= 1'b0;
            if (valid_out && (sof_out || framed_reg)) begin
                if (eof_out) begin
                    count_reg       <= acc_next;
                    count_valid_reg <= 1'b1;
                    acc_reg         <= '0;
                    framed_reg      <= 1'b0;
                end else begin
                    acc_reg    <= acc_next;
                    framed_reg <= 1'b1;
                end
            end
        end
    end

    assign count_out       = count_reg;
    assign count_valid_out = count_valid_reg;
`else
    assign count_out       = '0;
    assign count_valid_out = 1'b0;
`endif

endmodule

// File: tb/tb_threshold_pipe.sv
module tb_threshold_pipe;

    localparam int  CW   = 17;
    localparam longint CMAX = (64'd1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid = 1'b0, sof = 1'b0, eof = 1'b0, cfg = 1'b0;
    logic [31:0] ch = '0;
    logic [2:0]  sel = '0;
    logic [3:0]  lo = '0, up = '0;

    // 8-channel instance
    logic          a_valid, a_sof, a_eof, a_mask, a_cntv;
    logic [3:0]    a_ch;
    logic [CW-1:0] a_cnt;
    // 6-channel instance (select values 6 and 7 are out of range)
    logic          b_valid, b_sof, b_eof, b_mask, b_cntv;
    logic [3:0]    b_ch;
    logic [CW-1:0] b_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    threshold_pipe #(.WIDTH(4), .NUM_CH(8), .CNT_W(CW)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid), .sof_in(sof),
        .eof_in(eof), .ch_in(ch), .sel_in(sel), .lower_in(lo),
        .upper_in(up), .cfg_load_in(cfg), .valid_out(a_valid),
        .sof_out(a_sof), .eof_out(a_eof), .mask_out(a_mask),
        .channel_out(a_ch), .count_out(a_cnt), .count_valid_out(a_cntv)
    );

    threshold_pipe #(.WIDTH(4), .NUM_CH(6), .CNT_W(CW)) dut6 (
        .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid), .sof_in(sof),
        .eof_in(eof), .ch_in(ch[23:0]), .sel_in(sel), .lower_in(lo),
        .upper_in(up), .cfg_load_in(cfg), .valid_out(b_valid),
        .sof_out(b_sof), .eof_out(b_eof), .mask_out(b_mask),
        .channel_out(b_ch), .count_out(b_cnt), .count_valid_out(b_cntv)
    );

    // ---------------- reference model ----------------
    // Configuration: what is pending and what the current frame uses.
    logic [2:0] m_sh_sel, m_act_sel;
    logic [3:0] m_sh_lo, m_act_lo, m_sh_up, m_act_up;
    // Pixel accepted on the last call; it appears on the outputs one call later.
    logic       p_v, p_s, p_e, p_m8, p_m6;
    logic [3:0] p_ch8, p_ch6;
    // Expected output state
    logic          e_valid, e_sof, e_eof, e_m8, e_m6, e_cntv;
    logic [3:0]    e_ch8, e_ch6;
    logic [CW-1:0] e_cnt;
    longint        m_acc;
    bit            m_framed;

    function automatic logic [3:0] pick(input logic [31:0] c, input logic [2:0] s, input int n);
        if (int'(s) >= n) return 4'h0;
        return c[int'(s)*4 +: 4];
    endfunction

    function automatic logic [25:0] obs_vec();
        return {a_valid, a_sof, a_eof, a_mask, a_ch, a_cntv, a_cnt};
    endfunction

    function automatic logic [25:0] exp_vec();
        return {e_valid, e_sof, e_eof, e_m8, e_ch8, e_cntv, e_cnt};
    endfunction

    task automatic model_reset();
        m_sh_sel = 0; m_act_sel = 0;
        m_sh_lo = 0;  m_act_lo = 0;
        m_sh_up = 4'hF; m_act_up = 4'hF;
        {p_v, p_s, p_e, p_m8, p_m6} = '0; p_ch8 = 0; p_ch6 = 0;
        {e_valid, e_sof, e_eof, e_m8, e_m6, e_cntv} = '0;
        e_ch8 = 0; e_ch6 = 0; e_cnt = 0;
        m_acc = 0; m_framed = 0;
    endtask

    // Drive one clock of stimulus and advance the model to the output state
    // that should be visible just after that clock edge.
    task automatic apply(input logic v, input logic s, input logic e,
                         input logic [31:0] c, input logic cl,
                         input logic [2:0] cs, input logic [3:0] clo,
                         input logic [3:0] cup);
        longint sum;
        bit nv;
        nv = 0;
`ifdef THRESH_COUNT_EN
        // Frame count: restart on the sof pixel, report on the eof pixel.
        if (e_valid && (e_sof || m_framed)) begin
            sum = e_sof ? 0 : m_acc;
            if (e_m8 && sum < CMAX) sum = sum + 1;
            if (e_eof) begin
                e_cnt = CW'(sum); nv = 1; m_acc = 0; m_framed = 0;
            end else begin
                m_acc = sum; m_framed = 1;
            end
        end
`endif
        e_cntv = nv;
        e_valid = p_v; e_sof = p_s; e_eof = p_e;
        e_m8 = p_v && p_m8; e_m6 = p_v && p_m6;
        if (p_v) begin e_ch8 = p_ch8; e_ch6 = p_ch6; end
        if (v && s) begin
            m_act_sel = m_sh_sel; m_act_lo = m_sh_lo; m_act_up = m_sh_up;
        end
        p_v = v; p_s = v && s; p_e = v && e;
        p_ch8 = pick(c, m_act_sel, 8);
        p_ch6 = pick(c, m_act_sel, 6);
        p_m8 = (p_ch8 > m_act_lo) && (p_ch8 < m_act_up);
        p_m6 = (p_ch6 > m_act_lo) && (p_ch6 < m_act_up);
        if (cl) begin m_sh_sel = cs; m_sh_lo = clo; m_sh_up = cup; end
        valid = v; sof = v && s; eof = v && e; ch = c;
        cfg = cl; sel = cs; lo = clo; up = cup;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0; valid = 0; sof = 0; eof = 0; cfg = 0;
        #1;
        tests++;
        if (obs_vec() !== 26'd0 || {b_valid, b_mask, b_ch, b_cntv, b_cnt} !== 23'd0) begin
            fails++;
            $display("FAIL %s outputs during reset: got %h / %h, required 0", name,
                     obs_vec(), {b_valid, b_mask, b_ch, b_cntv, b_cnt});
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset("reset");
        for (int i = 1; i <= 4; i++) begin
            apply(1, 0, 0, 32'h5555_5555, 0, 0, 0, 0);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL reset cyc%0d got %h required %h", i, obs_vec(), exp_vec());
            end
            if (i == 2) begin
                tests++;
                if (a_mask !== 1'b1 || a_valid !== 1'b1) begin
                    fails++; $display("FAIL reset_mask got mask=%b valid=%b required 1/1", a_mask, a_valid);
                end
            end
        end
    endtask

    task automatic test_bounds();
        logic [3:0]  vals [4] = '{4'd3, 4'd4, 4'd8, 4'd9};
        logic        want [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] c;
        apply(0, 0, 0, $urandom, 1, 3'd2, 4'd3, 4'd9);
        for (int i = 0; i < 6; i++) begin
            c = $urandom;
            if (i < 4) c[11:8] = vals[i];
            apply(i < 4, i == 0, i == 3, c, 0, 0, 0, 0);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL bounds cyc%0d got %h required %h", i, obs_vec(), exp_vec());
            end
            if (i >= 1 && i <= 4) begin
                tests++;
                if (a_mask !== want[i-1] || a_ch !== vals[i-1]) begin
                    fails++; $display("FAIL bounds_px%0d got mask=%b ch=%0d required mask=%b ch=%0d",
                                      i-1, a_mask, a_ch, want[i-1], vals[i-1]);
                end
            end
        end
    endtask

    task automatic test_cfg_race();
        // frame A: sel=1 load coincides with sof -> still channel 2 (old shadow)
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 5; i++) begin
                apply(i < 4, i == 0, i == 3, $urandom, (f == 0 && i == 0), 3'd1, 4'd0, 4'd15);
                tests++;
                if (obs_vec() !== exp_vec()) begin
                    fails++; $display("FAIL cfg_race f%0d cyc%0d got %h required %h", f, i, obs_vec(), exp_vec());
                end
            end
        end
    endtask

    task automatic test_counter();
        logic [3:0] vals [10] = '{4'd5, 4'd2, 4'd7, 4'd12, 4'd9, 4'd0, 4'd4, 4'd11, 4'd3, 4'd10};
        logic [31:0] c;
        int px, pulses, eof_cyc, pulse_cyc;
        logic [CW-1:0] got;
        px = 0; pulses = 0; eof_cyc = -1; pulse_cyc = -1; got = '0;
        apply(0, 0, 0, $urandom, 1, 3'd0, 4'd3, 4'd12);
        for (int i = 0; i < 16; i++) begin
            c = $urandom;
            if (i == 3 || i == 8 || px >= 10) begin
                apply(0, 0, 0, c, 0, 0, 0, 0);
            end else begin
                c[3:0] = vals[px];
                apply(1, px == 0, px == 9, c, 0, 0, 0, 0);
                px++;
            end
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL counter cyc%0d got %h required %h", i, obs_vec(), exp_vec());
            end
            if (a_eof && a_valid) eof_cyc = i;
            if (a_cntv) begin pulses++; pulse_cyc = i; got = a_cnt; end
        end
`ifdef THRESH_COUNT_EN
        tests++;
        if (pulses != 1 || got !== CW'(6) || pulse_cyc != eof_cyc + 1) begin
            fails++; $display("FAIL counter_total got pulses=%0d count=%0d at %0d required 1/6 at %0d",
                              pulses, got, pulse_cyc, eof_cyc + 1);
        end
`else
        tests++;
        if (pulses != 0 || a_cnt !== '0) begin
            fails++; $display("FAIL counter_off got pulses=%0d count=%0d required 0/0", pulses, a_cnt);
        end
`endif
    endtask

    task automatic test_degenerate();
        for (int f = 0; f < 2; f++) begin
            // f=0: sel=6 (invalid for 6 channels); f=1: lower=upper=7
            apply(0, 0, 0, $urandom, 1, (f == 0) ? 3'd6 : 3'd1,
                  (f == 0) ? 4'd0 : 4'd7, (f == 0) ? 4'd15 : 4'd7);
            for (int i = 0; i < 10; i++) begin
                apply(i < 8, i == 0, i == 7, $urandom, 0, 0, 0, 0);
                tests++;
                if (obs_vec() !== exp_vec()) begin
                    fails++; $display("FAIL degen8 f%0d cyc%0d got %h required %h", f, i, obs_vec(), exp_vec());
                end
                tests++;
                if ({b_mask, b_ch} !== {e_m6, e_ch6}) begin
                    fails++; $display("FAIL degen6 f%0d cyc%0d got mask=%b ch=%0d required mask=%b ch=%0d",
                                      f, i, b_mask, b_ch, e_m6, e_ch6);
                end
                if (i >= 1 && i <= 8) begin
                    tests++;
                    if (b_mask !== 1'b0 || (f == 0 && b_ch !== 4'd0)) begin
                        fails++; $display("FAIL degen_const f%0d cyc%0d got mask=%b ch=%0d required mask=0", f, i, b_mask, b_ch);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        apply(0, 0, 0, $urandom, 1, 3'd0, 4'd0, 4'd15);
        for (int i = 0; i < 5; i++) apply(1, i == 0, 0, $urandom, 0, 0, 0, 0);
        do_reset("reset_mid");
        // remainder of the interrupted frame, then one complete frame
        for (int i = 0; i < 16; i++) begin
            apply(i != 5 && i < 13, i == 6, i == 4 || i == 12, $urandom, 0, 0, 0, 0);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL reset_mid cyc%0d got %h required %h", i, obs_vec(), exp_vec());
            end
            if (a_cntv) pulses++;
            if (i == 8) begin
                tests++;
                if (pulses != 0) begin
                    fails++; $display("FAIL reset_mid_nocount got %0d pulses required 0", pulses);
                end
            end
        end
    endtask

    task automatic test_random();
        int left;
        bit v, s, e, cl;
        left = 0;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            s = 0; e = 0;
            if (v) begin
                if (left == 0) begin left = $urandom_range(1, 8); s = 1; end
                e = (left == 1);
                left--;
            end
            cl = ($urandom_range(0, 7) == 0);
            apply(v, s, e, $urandom, cl, 3'($urandom), 4'($urandom), 4'($urandom));
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL random cyc%0d got %h required %h", i, obs_vec(), exp_vec());
            end
            tests++;
            if ({b_mask, b_ch} !== {e_m6, e_ch6}) begin
                fails++; $display("FAIL random6 cyc%0d got mask=%b ch=%0d required mask=%b ch=%0d",
                                  i, b_mask, b_ch, e_m6, e_ch6);
            end
        end
    endtask

    initial begin
        model_reset();
        #2;
        test_reset();
        test_bounds();
        test_cfg_race();
        test_counter();
        test_degenerate();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
